// File: rtl/wishbone_pkg.sv
// Shared types for the classic Wishbone controller.
package wishbone_pkg;
   typedef enum logic [1:0] {IDLE, BUS, RESP} wb_ctrl_state_t;
   localparam int CNT_W = 8;
endpackage

// File: rtl/wb_timeout_counter.sv
// Counts bus cycles without ack; expired flags the edge that reaches TIMEOUT.
module wb_timeout_counter
   import wishbone_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      count <= '0;
      else if (clear)   count <= '0;
      else if (enable)  count <= count + 1'b1;
   end

   // The edge that would make count equal TIMEOUT is the expiring edge.
   assign expired = enable && (count == LAST);
endmodule

// File: rtl/wishbone_ctrl_classic.sv
// Single-outstanding Wishbone B4 classic controller with timeout and
// valid/ready command and response handshakes.
module wishbone_ctrl_classic
   import wishbone_pkg::*;
#(
   parameter int DAT_WIDTH = 8,
   parameter int ADR_WIDTH = 8,
   parameter int TIMEOUT   = 15
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_we,
   input  logic [ADR_WIDTH-1:0] cmd_adr,
   input  logic [DAT_WIDTH-1:0] cmd_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DAT_WIDTH-1:0] rsp_rdata,
   output logic                 rsp_err,
   output logic                 wb_cyc_o,
   output logic                 wb_stb_o,
   output logic                 wb_we_o,
   output logic [ADR_WIDTH-1:0] wb_adr_o,
   output logic [DAT_WIDTH-1:0] wb_dat_o,
   input  logic [DAT_WIDTH-1:0] wb_dat_i,
   input  logic                 wb_ack_i
);
   wb_ctrl_state_t state;
   logic           expired;

   assign cmd_ready = (state == IDLE);

   wb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear   (state == IDLE),
      .enable  ((state == BUS) && !wb_ack_i),
      .expired (expired)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= IDLE;
         wb_cyc_o  <= 1'b0;
         wb_stb_o  <= 1'b0;
         wb_we_o   <= 1'b0;
         wb_adr_o  <= '0;
         wb_dat_o  <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (cmd_valid) begin
               state    <= BUS;
               wb_cyc_o <= 1'b1;
               wb_stb_o <= 1'b1;
               wb_we_o  <= cmd_we;
               wb_adr_o <= cmd_adr;
               wb_dat_o <= cmd_wdata;
            end
            BUS: begin
               // Ack takes priority over a coincident timeout.
               if (wb_ack_i) begin
                  state     <= RESP;
                  wb_cyc_o  <= 1'b0;
                  wb_stb_o  <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= wb_we_o ? '0 : wb_dat_i;
               end else if (expired) begin
                  state     <= RESP;
                  wb_cyc_o  <= 1'b0;
                  wb_stb_o  <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end
            end
            RESP: if (rsp_ready) begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
